mem_line_bridge: RTL and testbench
==================================

MEM_LINE_BRIDGE -- requirements
Module: mem_line_bridge

Interface
REQ-001 Parameter WORD, default 32, data word and address width in bits.
REQ-002 Parameter LINE_WORDS, default 4, words per cache line; line width is WORD*LINE_WORDS (128 at defaults).
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req_valid  in  1  DCache memory request; level, held high until resp_ready.
REQ-006 req_store  in  1  1 = single-word store, 0 = line refill load.
REQ-007 req_addr  in  WORD  byte address of the access.
REQ-008 req_wdata  in  WORD  store data.
REQ-009 resp_ready  out  1  one-cycle completion pulse to DCache.
REQ-010 line_data  out  WORD*LINE_WORDS  assembled refill line; word i at bits [WORD*i+WORD-1 : WORD*i].
REQ-011 bus_req  out  1  word bus request.
REQ-012 bus_we  out  1  word bus write enable.
REQ-013 bus_addr  out  WORD  word bus byte address, bits [1:0] always 0.
REQ-014 bus_wdata  out  WORD  word bus write data.
REQ-015 bus_gnt  in  1  bus accepts the request in the cycle bus_req and bus_gnt are both high.
REQ-016 bus_rvalid  in  1  read data valid, at least one cycle after the accepting grant.
REQ-017 bus_rdata  in  WORD  read data.

Function
REQ-018 States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, DONE; all transitions on the rising clk edge.
REQ-019 In IDLE, req_valid=1 captures req_addr, req_wdata and req_store into internal registers; next state is WR_ISSUE if req_store=1, otherwise RD_ISSUE with word counter cnt=0.
REQ-020 Load base address is the captured address with its low log2(LINE_WORDS*WORD/8) bits cleared; the word-i address is base + 4*i.
REQ-021 RD_ISSUE: bus_req=1, bus_we=0, bus_addr = base + 4*cnt; on bus_gnt go to RD_WAIT, otherwise hold all outputs.
REQ-022 RD_WAIT: bus_req=0; on bus_rvalid write bus_rdata into line slot cnt; if cnt=LINE_WORDS-1 go to DONE, else cnt+1 and go to RD_ISSUE.
REQ-023 Only one bus transaction is outstanding at a time; bus_rvalid in any state other than RD_WAIT is ignored.
REQ-024 WR_ISSUE: bus_req=1, bus_we=1, bus_addr = captured address with bits [1:0] zeroed, bus_wdata = captured data; on bus_gnt go to DONE.
REQ-025 DONE: resp_ready=1 for exactly this cycle; next state is IDLE; req_valid is ignored in DONE.
REQ-026 resp_ready is 0 in every state except DONE.
REQ-027 Minimum latency (gnt same cycle, rvalid next cycle): load = 2*LINE_WORDS+2 cycles from req_valid sampled to the resp_ready cycle (10 at defaults); store = 3 cycles.
REQ-028 line_data is updated only by RD_WAIT captures; it is stable from the resp_ready cycle until the next load's first capture; stores do not modify it.
REQ-029 Slots not yet written during a refill keep their previous values; resp_ready is never asserted with a partial line.
REQ-030 bus_wdata is 0 and bus_we is 0 whenever the state is not WR_ISSUE.
REQ-031 Input changes on req_addr, req_wdata or req_store after capture have no effect until the next IDLE capture.
REQ-032 A stall of any length (bus_gnt or bus_rvalid held low) holds the state, cnt and all bus outputs unchanged.

Reset
REQ-033 rst=1 immediately forces state IDLE, cnt=0, resp_ready=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, line_data=0 and clears captured registers, independent of clk.
REQ-034 Reset during any non-IDLE state abandons the transaction; a bus_rvalid arriving after reset release is ignored.
REQ-035 The first capture is possible on the first rising edge after rst falls.

Verification
REQ-036 Load req_addr=0x0000_1234, zero-wait bus returning 0xA0,0xA1,0xA2,0xA3 -> bus_addr sequence 0x1230, 0x1234, 0x1238, 0x123C; resp_ready on cycle 10; line_data=0x000000A3_000000A2_000000A1_000000A0.
REQ-037 Store req_addr=0x0000_2007, req_wdata=0xDEADBEEF, bus_gnt delayed 3 cycles -> bus_req/bus_we held with bus_addr=0x2004 for 4 cycles; one resp_ready pulse; line_data unchanged.
REQ-038 Load with random gnt/rvalid stalls and spurious bus_rvalid during RD_ISSUE -> spurious data discarded; correct line; exactly one resp_ready pulse.
REQ-039 rst asserted mid-refill after 2 words -> all outputs 0 asynchronously; a late bus_rvalid is ignored; next load completes with a correct line.
REQ-040 req_valid held high through DONE, then a back-to-back store followed by a load -> no duplicate transaction; each completes with one resp_ready pulse, in order.

Source files
------------

// File: rtl/mem_line_bridge_if.sv
// rtl/mem_line_bridge_if.sv - DCache request/response and word-bus signal bundle for mem_line_bridge
interface mem_line_bridge_if #(
   parameter int WORD       = 32,
   parameter int LINE_WORDS = 4
);
   logic                       req_valid;
   logic                       req_store;
   logic [WORD-1:0]            req_addr;
   logic [WORD-1:0]            req_wdata;
   logic                       resp_ready;
   logic [WORD*LINE_WORDS-1:0] line_data;
   logic                       bus_req;
   logic                       bus_we;
   logic [WORD-1:0]            bus_addr;
   logic [WORD-1:0]            bus_wdata;
   logic                       bus_gnt;
   logic                       bus_rvalid;
   logic [WORD-1:0]            bus_rdata;

   // Bridge side
   modport slave (
      input  req_valid, req_store, req_addr, req_wdata,
      input  bus_gnt, bus_rvalid, bus_rdata,
      output resp_ready, line_data,
      output bus_req, bus_we, bus_addr, bus_wdata
   );

   // DCache plus word-bus environment side
   modport master (
      output req_valid, req_store, req_addr, req_wdata,
      output bus_gnt, bus_rvalid, bus_rdata,
      input  resp_ready, line_data,
      input  bus_req, bus_we, bus_addr, bus_wdata
   );
endinterface

// File: rtl/mem_line_bridge.sv
// rtl/mem_line_bridge.sv - DCache line refill / single-word store bridge onto a one-outstanding word bus
module mem_line_bridge #(
   parameter int WORD       = 32,
   parameter int LINE_WORDS = 4
) (
   input logic               clk,
   input logic               rst,
   mem_line_bridge_if.slave  io
);
   localparam int                 LINE_BYTES = LINE_WORDS * WORD / 8;
   localparam int                 CNT_W      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam logic [WORD-1:0]    LINE_MASK  = WORD'(LINE_BYTES - 1);
   localparam logic [WORD-1:0]    WORD_MASK  = WORD'(3);
   localparam logic [CNT_W-1:0]   LAST_CNT   = CNT_W'(LINE_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_ISSUE,
      S_RD_WAIT,
      S_WR_ISSUE,
      S_DONE
   } state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic [CNT_W-1:0]           r_cnt;
   logic [CNT_W-1:0]           w_cnt_nxt;
   logic [WORD-1:0]            r_addr;
   logic [WORD-1:0]            r_wdata;
   logic [WORD*LINE_WORDS-1:0] r_line;

   logic                       w_capture;
   logic                       w_fill;
   logic [WORD-1:0]            w_base;
   logic [WORD-1:0]            w_rd_addr;
   logic                       w_resp_ready;
   logic                       w_bus_req;
   logic                       w_bus_we;
   logic [WORD-1:0]            w_bus_addr;
   logic [WORD-1:0]            w_bus_wdata;

   assign w_base    = r_addr & ~LINE_MASK;
   assign w_rd_addr = w_base + (WORD'(r_cnt) << 2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_capture) begin
         r_addr  <= io.req_addr;
         r_wdata <= io.req_wdata;
      end
   end

   // Only the slot addressed by cnt changes; untouched slots keep their old contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_line <= '0;
      end else if (w_fill) begin
         for (int i = 0; i < LINE_WORDS; i++) begin
            if (r_cnt == CNT_W'(i)) begin
               r_line[i*WORD +: WORD] <= io.bus_rdata;
            end
         end
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_capture    = 1'b0;
      w_fill       = 1'b0;
      w_resp_ready = 1'b0;
      w_bus_req    = 1'b0;
      w_bus_we     = 1'b0;
      w_bus_addr   = '0;
      w_bus_wdata  = '0;

      case (r_state)
         S_IDLE: begin
            if (io.req_valid) begin
               w_capture   = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = io.req_store ? S_WR_ISSUE : S_RD_ISSUE;
            end
         end
         S_RD_ISSUE: begin
            w_bus_req  = 1'b1;
            w_bus_addr = w_rd_addr;
            if (io.bus_gnt) begin
               w_state_nxt = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (io.bus_rvalid) begin
               w_fill = 1'b1;
               if (r_cnt == LAST_CNT) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_cnt_nxt   = r_cnt + CNT_W'(1);
                  w_state_nxt = S_RD_ISSUE;
               end
            end
         end
         S_WR_ISSUE: begin
            w_bus_req   = 1'b1;
            w_bus_we    = 1'b1;
            w_bus_addr  = r_addr & ~WORD_MASK;
            w_bus_wdata = r_wdata;
            if (io.bus_gnt) begin
               w_state_nxt = S_DONE;
            end
         end
         // req_valid is deliberately not looked at here so a held request is not re-captured.
         S_DONE: begin
            w_resp_ready = 1'b1;
            w_state_nxt  = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign io.resp_ready = w_resp_ready;
   assign io.line_data  = r_line;
   assign io.bus_req    = w_bus_req;
   assign io.bus_we     = w_bus_we;
   assign io.bus_addr   = w_bus_addr;
   assign io.bus_wdata  = w_bus_wdata;
endmodule

// File: tb/tb_mem_line_bridge.sv
// tb/tb_mem_line_bridge.sv - directed self-checking bench for mem_line_bridge
module tb_mem_line_bridge;
   logic         clk;
   logic         rst;
   int           n_checks;
   int           n_errors;
   logic [127:0] m_line;

   mem_line_bridge_if #(.WORD(32), .LINE_WORDS(4)) bif ();

   mem_line_bridge #(.WORD(32), .LINE_WORDS(4)) u_dut (
      .clk (clk),
      .rst (rst),
      .io  (bif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic reset_mid(input string tag);
      bif.req_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      check({tag, " rst resp_ready"}, bif.resp_ready, 0);
      check({tag, " rst bus_req"},    bif.bus_req, 0);
      check({tag, " rst bus_we"},     bif.bus_we, 0);
      check({tag, " rst bus_addr"},   bif.bus_addr, 0);
      check({tag, " rst bus_wdata"},  bif.bus_wdata, 0);
      check({tag, " rst line_data"},  bif.line_data, 0);
      @(negedge clk);
      rst            = 1'b0;
      bif.bus_rvalid = 1'b1;
      bif.bus_rdata  = 32'hDEAD_0001;
      @(negedge clk);
      bif.bus_rvalid = 1'b0;
      bif.bus_rdata  = '0;
      check({tag, " late rvalid resp"},  bif.resp_ready, 0);
      check({tag, " late rvalid req"},   bif.bus_req, 0);
      check({tag, " late rvalid line"},  bif.line_data, 0);
      m_line = '0;
   endtask

   // One DCache transaction against a word-bus responder with fixed stall counts.
   // Called on a negedge; the calling cycle is cycle 1 of the latency count.
   task automatic txn(input string tag, input bit st, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] dbase, input int gw,
                      input int rw, input bit spur, input int rst_after, input bit hold,
                      input int exp_lat);
      int cyc, k, gcnt, rcnt, lat, bad, writes, held;
      bit pend, done;
      logic [31:0] exp_addr;
      cyc = 1; k = 0; gcnt = 0; rcnt = 0; lat = 0; bad = 0; writes = 0; held = 0;
      pend = 1'b0; done = 1'b0;
      bif.req_valid = 1'b1;
      bif.req_store = st;
      bif.req_addr  = addr;
      bif.req_wdata = wd;
      while (!done && cyc < 300) begin
         @(negedge clk);
         cyc++;
         bif.bus_gnt    = 1'b0;
         bif.bus_rvalid = 1'b0;
         bif.bus_rdata  = '0;
         if (cyc == 3) begin
            bif.req_addr  = ~addr;
            bif.req_wdata = ~wd;
            bif.req_store = ~st;
         end
         if (!bif.bus_we && bif.bus_wdata != 0) bad++;
         if (bif.bus_we && !bif.bus_req) bad++;
         if (bif.resp_ready) begin
            lat  = cyc;
            done = 1'b1;
            if (!hold) bif.req_valid = 1'b0;
         end else if (rst_after >= 0 && k == rst_after && bif.bus_req) begin
            reset_mid(tag);
            return;
         end else if (bif.bus_req && !bif.bus_we) begin
            if (st) bad++;
            exp_addr = (addr & ~32'hF) + 32'(4 * k);
            if (bif.bus_addr != exp_addr) bad++;
            if (gcnt < gw) begin
               gcnt++;
               if (spur) begin
                  bif.bus_rvalid = 1'b1;
                  bif.bus_rdata  = 32'hBAD0_0000 | 32'(k);
               end
            end else begin
               bif.bus_gnt = 1'b1;
               gcnt = 0;
               pend = 1'b1;
            end
         end else if (bif.bus_req && bif.bus_we) begin
            held++;
            if (!st) bad++;
            if (bif.bus_addr != (addr & ~32'h3)) bad++;
            if (bif.bus_wdata != wd) bad++;
            if (gcnt < gw) begin
               gcnt++;
            end else begin
               bif.bus_gnt = 1'b1;
               writes++;
            end
         end else if (pend) begin
            if (rcnt < rw) begin
               rcnt++;
            end else begin
               bif.bus_rvalid = 1'b1;
               bif.bus_rdata  = dbase + 32'(k);
               k++;
               rcnt = 0;
               pend = 1'b0;
            end
         end
      end
      check({tag, " completed"}, done, 1);
      check({tag, " latency"},   lat, exp_lat);
      check({tag, " bus_usage"}, bad, 0);
      check({tag, " writes"},    writes, st ? 1 : 0);
      check({tag, " words"},     k, st ? 0 : 4);
      check({tag, " wr_held"},   held, st ? gw + 1 : 0);
      if (!st) begin
         for (int i = 0; i < 4; i++) m_line[i*32 +: 32] = dbase + 32'(i);
      end
      check({tag, " line_data"}, bif.line_data, m_line);
      if (!hold) begin
         @(negedge clk);
         bif.bus_gnt    = 1'b0;
         bif.bus_rvalid = 1'b0;
         check({tag, " single_pulse"}, bif.resp_ready, 0);
      end
   endtask

   initial begin
      int act;
      n_checks = 0;
      n_errors = 0;
      m_line   = '0;
      rst            = 1'b1;
      bif.req_valid  = 1'b0;
      bif.req_store  = 1'b0;
      bif.req_addr   = '0;
      bif.req_wdata  = '0;
      bif.bus_gnt    = 1'b0;
      bif.bus_rvalid = 1'b0;
      bif.bus_rdata  = '0;
      repeat (3) @(negedge clk);
      check("reset resp_ready", bif.resp_ready, 0);
      check("reset bus_req",    bif.bus_req, 0);
      check("reset bus_we",     bif.bus_we, 0);
      check("reset bus_addr",   bif.bus_addr, 0);
      check("reset bus_wdata",  bif.bus_wdata, 0);
      check("reset line_data",  bif.line_data, 0);
      rst = 1'b0;

      txn("ld_zero_wait", 0, 32'h0000_1234, 32'h0, 32'hA0, 0, 0, 0, -1, 0, 10);
      check("ld_line_literal", bif.line_data, 128'h000000A3_000000A2_000000A1_000000A0);

      txn("st_gnt_stall", 1, 32'h0000_2007, 32'hDEADBEEF, 32'h0, 3, 0, 0, -1, 0, 6);
      check("st_line_kept", bif.line_data, 128'h000000A3_000000A2_000000A1_000000A0);

      txn("ld_stall_spur", 0, 32'h0000_5678, 32'h0, 32'h100, 2, 1, 1, -1, 0, 22);

      txn("ld_reset", 0, 32'h0000_9ABC, 32'h0, 32'h10, 0, 0, 0, 2, 0, 0);
      txn("ld_after_rst", 0, 32'h0000_3FFC, 32'h0, 32'h55, 0, 0, 0, -1, 0, 10);

      txn("b2b_ld", 0, 32'h0000_7000, 32'h0, 32'h20, 0, 0, 0, -1, 1, 10);
      txn("b2b_st", 1, 32'h0000_4001, 32'h1234_5678, 32'h0, 0, 0, 0, -1, 1, 4);
      txn("b2b_ld2", 0, 32'h0000_8008, 32'h0, 32'hC0, 0, 0, 0, -1, 0, 11);

      act = 0;
      repeat (4) begin
         @(negedge clk);
         if (bif.bus_req || bif.resp_ready) act++;
      end
      check("idle_quiet", act, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
